// File: rtl/led_anim_pkg.sv
// Shared encodings for the LED animation slice: command modes, fade
// sequencer state codes and the default full-brightness duty code.
package led_anim_pkg;

    localparam logic [1:0] MODE_OFF      = 2'b00;
    localparam logic [1:0] MODE_FADE_IN  = 2'b01;
    localparam logic [1:0] MODE_FADE_OUT = 2'b10;
    localparam logic [1:0] MODE_BREATHE  = 2'b11;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_RAMP_UP = 3'd1;
    localparam logic [2:0] ST_HOLD_HI = 3'd2;
    localparam logic [2:0] ST_RAMP_DN = 3'd3;
    localparam logic [2:0] ST_HOLD_LO = 3'd4;

    localparam int DUTY_MAX_DEF = 10;

endpackage

// File: rtl/led_fade_seq_step_timer.sv
// Step timer: free-running tick 0..STEP_TICKS-1 while enabled, restarted
// by clear; step is high on the last tick of each period.
module step_timer #(
    parameter int STEP_TICKS = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic step
);

    localparam int            TW        = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(STEP_TICKS - 1);

    logic [TW-1:0] tick;

    // Tick counter, cleared on command accept and wrapping at the last tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick <= '0;
        end else if (clear) begin
            tick <= '0;
        end else if (enable) begin
            if (tick == TICK_LAST)
                tick <= '0;
            else
                tick <= tick + TW'(1);
        end
    end

    assign step = enable && (tick == TICK_LAST);

endmodule

// File: rtl/led_fade_seq.sv
// Fade sequencer driving one PWM channel's duty code.
//
// state      | meaning
// -----------+------------------------------------------------------
// ST_IDLE    | waiting for a command; cmd_ready high
// ST_RAMP_UP | duty +1 per step until DUTY_MAX
// ST_HOLD_HI | breathe only: HOLD_STEPS steps at DUTY_MAX
// ST_RAMP_DN | duty -1 per step until 0
// ST_HOLD_LO | breathe only: HOLD_STEPS steps at 0, or exit if stopped
//
// OFF and "already there" fades never go busy: they are latched as a
// pending action and applied, with the done pulse, on the following edge.
module led_fade_seq
    import led_anim_pkg::*;
#(
    parameter int STEP_TICKS = 20,
    parameter int DUTY_MAX   = DUTY_MAX_DEF,
    parameter int HOLD_STEPS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    input  logic [1:0] cmd_mode,
    output logic       cmd_ready,
    input  logic       stop,
    output logic [3:0] duty_cycle,
    output logic       busy,
    output logic       done
);

    localparam int            HW        = (HOLD_STEPS > 0) ? $clog2(HOLD_STEPS + 1) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_STEPS);
    localparam logic [3:0]    DMAX      = 4'(DUTY_MAX);
    localparam logic [3:0]    DMAX_M1   = 4'(DUTY_MAX - 1);

    logic [2:0]    state;
    logic          breathe;
    logic          stop_pend;
    logic          pend_zero;
    logic          pend_max;
    logic [HW-1:0] hold;
    logic [HW-1:0] hold_nxt;
    logic          accept;
    logic          step;

    assign busy      = (state != ST_IDLE);
    assign cmd_ready = ~busy;
    assign accept    = cmd_valid && cmd_ready;
    assign hold_nxt  = hold + HW'(1);

    step_timer #(
        .STEP_TICKS(STEP_TICKS)
    ) u_step_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (accept),
        .enable (busy),
        .step   (step)
    );

    // Sequencer FSM with duty register, hold counter and stop latch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            duty_cycle <= 4'd0;
            done       <= 1'b0;
            breathe    <= 1'b0;
            stop_pend  <= 1'b0;
            pend_zero  <= 1'b0;
            pend_max   <= 1'b0;
            hold       <= '0;
        end else begin
            done      <= 1'b0;
            pend_zero <= 1'b0;
            pend_max  <= 1'b0;
            if (pend_zero) begin
                duty_cycle <= 4'd0;
                done       <= 1'b1;
            end
            if (pend_max) begin
                duty_cycle <= DMAX;
                done       <= 1'b1;
            end
            if (busy && breathe && stop)
                stop_pend <= 1'b1;

            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        hold      <= '0;
                        stop_pend <= 1'b0;
                        breathe   <= 1'b0;
                        case (cmd_mode)
                            MODE_OFF: pend_zero <= 1'b1;
                            MODE_FADE_IN: begin
                                if (duty_cycle >= DMAX) pend_max <= 1'b1;
                                else                    state    <= ST_RAMP_UP;
                            end
                            MODE_FADE_OUT: begin
                                if (duty_cycle == 4'd0) pend_zero <= 1'b1;
                                else                    state     <= ST_RAMP_DN;
                            end
                            default: begin
                                breathe <= 1'b1;
                                state   <= ST_RAMP_UP;
                            end
                        endcase
                    end
                end
                ST_RAMP_UP: begin
                    if (step) begin
                        if (duty_cycle >= DMAX_M1) begin
                            duty_cycle <= DMAX;
                            if (breathe) begin
                                hold  <= '0;
                                state <= (HOLD_STEPS == 0) ? ST_RAMP_DN : ST_HOLD_HI;
                            end else begin
                                done  <= 1'b1;
                                state <= ST_IDLE;
                            end
                        end else begin
                            duty_cycle <= duty_cycle + 4'd1;
                        end
                    end
                end
                ST_HOLD_HI: begin
                    if (step) begin
                        hold <= hold_nxt;
                        if (hold_nxt == HOLD_LAST)
                            state <= ST_RAMP_DN;
                    end
                end
                ST_RAMP_DN: begin
                    if (step) begin
                        if (duty_cycle <= 4'd1) begin
                            duty_cycle <= 4'd0;
                            if (breathe && !stop_pend) begin
                                hold  <= '0;
                                state <= (HOLD_STEPS == 0) ? ST_RAMP_UP : ST_HOLD_LO;
                            end else begin
                                done      <= 1'b1;
                                state     <= ST_IDLE;
                                breathe   <= 1'b0;
                                stop_pend <= 1'b0;
                            end
                        end else begin
                            duty_cycle <= duty_cycle - 4'd1;
                        end
                    end
                end
                ST_HOLD_LO: begin
                    if (step) begin
                        if (stop_pend) begin
                            done      <= 1'b1;
                            state     <= ST_IDLE;
                            breathe   <= 1'b0;
                            stop_pend <= 1'b0;
                        end else begin
                            hold <= hold_nxt;
                            if (hold_nxt == HOLD_LAST)
                                state <= ST_RAMP_UP;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_led_fade_seq.sv
// Scoreboard bench for led_fade_seq (STEP_TICKS=4, DUTY_MAX=10, HOLD_STEPS=2).
// Stimulus pushes the expected visible events (edge offset from accept,
// duty, done, busy); a monitor pops and compares whenever duty or busy
// changes or done is high.
module tb_led_fade_seq;
    import led_anim_pkg::*;

    typedef struct {
        int         rel;
        logic [3:0] duty;
        logic       dn;
        logic       bs;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_mode = 2'b00;
    logic       stop = 1'b0;
    logic       cmd_ready;
    logic [3:0] duty_cycle;
    logic       busy;
    logic       done;

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_errors = 0;
    int  edge_n = 0;
    int  acc_edge = 0;

    led_fade_seq #(
        .STEP_TICKS(4),
        .DUTY_MAX  (10),
        .HOLD_STEPS(2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_mode  (cmd_mode),
        .cmd_ready (cmd_ready),
        .stop      (stop),
        .duty_cycle(duty_cycle),
        .busy      (busy),
        .done      (done)
    );

    // Clock generation.
    always #5 clk = ~clk;

    // Edge counter used to time events relative to the accept edge.
    always @(posedge clk) edge_n <= edge_n + 1;

    // Watchdog so the run always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int got, input int expv);
        n_checks++;
        if (got != expv) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d", name, got, expv);
        end
    endtask

    task automatic push(input int rel, input int duty, input bit dn, input bit bs);
        ev_t e;
        e.rel  = rel;
        e.duty = 4'(duty);
        e.dn   = dn;
        e.bs   = bs;
        exp_q.push_back(e);
    endtask

    task automatic push_fade_in();
        push(0, 0, 1'b0, 1'b1);
        for (int k = 1; k <= 9; k++) push(4 * k, k, 1'b0, 1'b1);
        push(40, 10, 1'b1, 1'b0);
    endtask

    task automatic push_fade_out();
        push(0, 10, 1'b0, 1'b1);
        for (int k = 1; k <= 9; k++) push(4 * k, 10 - k, 1'b0, 1'b1);
        push(40, 0, 1'b1, 1'b0);
    endtask

    // Breathe from 0 up to the end of the first ramp down (duty 1 at 84).
    task automatic push_breathe_to_84();
        push(0, 0, 1'b0, 1'b1);
        for (int k = 1; k <= 10; k++) push(4 * k, k, 1'b0, 1'b1);
        for (int j = 0; j <= 8; j++) push(52 + 4 * j, 9 - j, 1'b0, 1'b1);
    endtask

    task automatic issue(input logic [1:0] mode);
        bit got;
        got = 1'b0;
        @(posedge clk);
        #1;
        cmd_mode  = mode;
        cmd_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                got = 1'b1;
                break;
            end
        end
        chk("accept_seen", int'(got), 1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        acc_edge  = edge_n;
    endtask

    task automatic drain(input string name, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        chk({name, "_pending_events"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic async_reset(input string name);
        #3;
        rst = 1'b1;
        #1;
        chk({name, "_duty"}, int'(duty_cycle), 0);
        chk({name, "_busy"}, int'(busy), 0);
        chk({name, "_done"}, int'(done), 0);
        chk({name, "_ready"}, int'(cmd_ready), 1);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic monitor();
        logic [3:0] pd;
        logic       pb;
        ev_t        e;
        int         rel;
        pd = 4'd0;
        pb = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pd = duty_cycle;
                pb = busy;
            end else begin
                chk("ready_vs_busy", int'(cmd_ready), int'(!busy));
                chk("done_while_busy", int'(done && busy), 0);
                if (duty_cycle !== pd || busy !== pb || done === 1'b1) begin
                    rel = edge_n - acc_edge;
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        n_errors++;
                        $display("FAIL unexpected_event rel=%0d duty=%0d done=%0b busy=%0b",
                                 rel, duty_cycle, done, busy);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.rel != rel || e.duty !== duty_cycle || e.dn !== done || e.bs !== busy) begin
                            n_errors++;
                            $display("FAIL event got rel=%0d duty=%0d done=%0b busy=%0b exp rel=%0d duty=%0d done=%0b busy=%0b",
                                     rel, duty_cycle, done, busy, e.rel, e.duty, e.dn, e.bs);
                        end
                    end
                end
                pd = duty_cycle;
                pb = busy;
            end
        end
    endtask

    // Stimulus; the monitor runs as a forked child of this block.
    initial begin
        int first_acc;
        int low;

        fork
            monitor();
        join_none

        #12;
        chk("reset_duty", int'(duty_cycle), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_ready", int'(cmd_ready), 1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        push_fade_in();
        issue(MODE_FADE_IN);
        drain("fade_in", 80);

        push(1, 10, 1'b1, 1'b0);
        issue(MODE_FADE_IN);
        drain("fade_in_at_max", 10);

        push(1, 0, 1'b1, 1'b0);
        issue(MODE_OFF);
        drain("off_at_max", 10);

        push_fade_in();
        push_fade_out();
        issue(MODE_FADE_IN);
        first_acc = acc_edge;
        cmd_mode  = MODE_FADE_OUT;
        cmd_valid = 1'b1;
        low = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (cmd_ready) break;
            low++;
        end
        chk("ready_low_cycles", low, 40);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        acc_edge  = edge_n;
        chk("held_accept_edge", acc_edge - first_acc, 41);
        drain("held_fade_out", 80);

        push(1, 0, 1'b1, 1'b0);
        issue(MODE_FADE_OUT);
        drain("fade_out_at_zero", 10);

        push_breathe_to_84();
        push(88, 0, 1'b1, 1'b0);
        issue(MODE_BREATHE);
        repeat (19) @(posedge clk);
        #1;
        stop = 1'b1;
        @(posedge clk);
        #1;
        stop = 1'b0;
        drain("breathe_stop", 120);

        push_breathe_to_84();
        push(88, 0, 1'b0, 1'b1);
        push(100, 1, 1'b0, 1'b1);
        issue(MODE_BREATHE);
        drain("breathe_loop", 140);
        @(posedge clk);
        async_reset("reset_breathe");

        push(0, 0, 1'b0, 1'b1);
        for (int k = 1; k <= 5; k++) push(4 * k, k, 1'b0, 1'b1);
        issue(MODE_FADE_IN);
        drain("ramp_to_5", 40);
        async_reset("reset_mid_ramp");

        repeat (3) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
